imem_fetch_responder: RTL and testbench
=======================================

# imem_fetch_responder

Instruction-memory responder on the fetch side of the RV32I pipeline. It accepts fetch requests (PC) from the fetch stage over a valid/ready handshake and returns the addressed instruction after a parameterised number of wait states. It holds each response stable under ID stalls, and discards in-flight work on a branch flush. A loader write port fills the instruction array; out-of-range or misaligned fetches return a flagged NOP.

## Interface
- REG_DATA_WIDTH, 32, instruction/data word width
- IMEM_ADDR_WIDTH, 32, byte-address width of requests
- IMEM_DATA_DEPTH, 1024, number of 32-bit words in the array
- WAIT_STATES, 1, extra cycles per access, legal range 0..7

- Clk_100MHz  in  1  pipeline clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-high reset
- IF_req_valid  in  1  fetch request present
- IF_req_addr  in  IMEM_ADDR_WIDTH  byte address (PC) of the request
- IF_req_ready  out  1  request accepted on an edge where valid&&ready
- IF_rsp_valid  out  1  response present
- IF_rsp_instr  out  REG_DATA_WIDTH  fetched instruction
- IF_rsp_addr  out  IMEM_ADDR_WIDTH  echoed request address
- IF_rsp_error  out  1  misaligned or out-of-range fetch
- IF_rsp_ready  in  1  consumer (ID) takes response; low = stall
- IF_flush  in  1  branch taken: abandon request/response in flight
- Prog_we  in  1  loader write strobe
- Prog_addr  in  IMEM_ADDR_WIDTH  loader byte address (bits [1:0] ignored)
- Prog_wdata  in  REG_DATA_WIDTH  loader write data

## Operation
- States: IDLE, WAIT, RESP. There is a 3-bit wait counter.
- Behaviour in IDLE:
  - IF_req_ready = !Prog_we && !IF_flush.
  - On accept, latch the address.
  - If WAIT_STATES = 0, go to RESP and sample the array.
  - Otherwise load counter = WAIT_STATES and go to WAIT.
- Behaviour in WAIT:
  - IF_req_ready = 0.
  - Counter decrements each cycle.
  - On the edge where the counter is 1, sample the array and go to RESP.
- Behaviour in RESP:
  - IF_rsp_valid = 1. Instr, addr and error are held stable until IF_rsp_valid && IF_rsp_ready.
  - IF_req_ready = IF_rsp_ready && !Prog_we && !IF_flush, so a new request is accepted on the same edge that the current response is consumed.
  - On consume with a new accept, follow the IDLE accept rules.
  - On consume with no accept, go to IDLE.
- Error condition: IF_req_addr[1:0] != 0, or word index IF_req_addr >> 2 >= IMEM_DATA_DEPTH.
  - Response is IF_rsp_error = 1 and IF_rsp_instr = 0x00000013 (NOP).
  - Latency is unchanged.
  - The array is not read.
- Flush: IF_flush high on an edge forces IDLE from any state.
  - The pending response is dropped and the counter is cleared.
  - No request is accepted on that edge.
- Loader port:
  - Prog_we writes mem[Prog_addr >> 2] on the edge in any state.
  - Writes with an out-of-range index are ignored.
  - A write and a read sample of the same word on the same edge return the OLD data.
  - A write during WAIT to the pending word is visible in the response.
- The array is not cleared by Reset.

## Timing
- Reset values (from the edge where Reset = 1):
  - state IDLE
  - IF_rsp_valid 0
  - IF_rsp_instr 0x00000013
  - IF_rsp_addr 0
  - IF_rsp_error 0
  - IF_req_ready 0 while Reset is high
- Reset mid-access discards everything. The first accept is possible on the first edge after Reset falls.
- Latency: a request accepted on edge k gives IF_rsp_valid = 1 in the cycle after edge k + WAIT_STATES.
- Throughput:
  - WAIT_STATES = 0 with IF_rsp_ready held high gives one instruction per cycle.
  - Otherwise one instruction per WAIT_STATES + 1 cycles.
- Stall: while IF_rsp_ready = 0 in RESP, all response outputs hold bit-stable and IF_req_ready = 0.
- Precedence of simultaneous events, highest first: Reset, then IF_flush, then Prog_we (blocks accept), then handshake.
- Outputs are registered. IF_req_ready is the only combinational output, driven from state, IF_rsp_ready, Prog_we and IF_flush.

## Test plan
- Load, then fetch at W=1:
  - Program mem[0..3] = 0x00500093, 0x00100113, 0x002081B3, 0x00000013.
  - Request addr 0x0 with ready high.
  - Response 0x00500093, addr 0x0, valid 2 cycles after the request cycle.
  - Sequential 0x4/0x8/0xC follow at one per 2 cycles.
- Streaming at W=0: requests 0x0..0xC on consecutive cycles with IF_rsp_ready = 1 give 4 responses in 4 consecutive cycles, in order, with no bubbles.
- Stall:
  - Hold IF_rsp_ready = 0 for 3 cycles in RESP with addr 0x4.
  - IF_rsp_instr stays 0x00100113 and IF_req_ready stays 0.
  - The release edge consumes the response and accepts the next request.
- Flush during WAIT (W=3): assert IF_flush one cycle after accepting 0x8.
  - No response for 0x8.
  - The next request 0x40 returns mem[16] only.
- Error cases:
  - Request 0x6 gives error = 1 and instr 0x00000013.
  - Request 0x1000 (index 1024) gives error = 1 and instr 0x00000013.
  - Latency is identical to a normal fetch.
- Reset and write collision:
  - Reset asserted in RESP clears valid the next cycle, and instr reads 0x00000013.
  - Array contents persist across the reset.
  - A Prog_we to 0x0 on the sampling edge returns the old word; a re-fetch returns the new word.

Source files
------------

// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder with a fixed number of wait states.
// Holds responses under ID stalls, drops work on flush, and has a loader write port.
module imem_fetch_responder #(
  parameter int REG_DATA_WIDTH  = 32,
  parameter int IMEM_ADDR_WIDTH = 32,
  parameter int IMEM_DATA_DEPTH = 1024,
  parameter int WAIT_STATES     = 1
) (
  input  logic                       Clk_100MHz,
  input  logic                       Reset,
  input  logic                       IF_req_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] IF_req_addr,
  output logic                       IF_req_ready,
  output logic                       IF_rsp_valid,
  output logic [REG_DATA_WIDTH-1:0]  IF_rsp_instr,
  output logic [IMEM_ADDR_WIDTH-1:0] IF_rsp_addr,
  output logic                       IF_rsp_error,
  input  logic                       IF_rsp_ready,
  input  logic                       IF_flush,
  input  logic                       Prog_we,
  input  logic [IMEM_ADDR_WIDTH-1:0] Prog_addr,
  input  logic [REG_DATA_WIDTH-1:0]  Prog_wdata
);

  localparam int IDX_W =
    (IMEM_DATA_DEPTH > 1) ? $clog2(IMEM_DATA_DEPTH) : 1;
  localparam logic [REG_DATA_WIDTH-1:0] NOP =
    REG_DATA_WIDTH'(32'h0000_0013);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  localparam logic [IMEM_ADDR_WIDTH-1:0] DEPTH =
    IMEM_ADDR_WIDTH'(IMEM_DATA_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic in_range(
    input logic [IMEM_ADDR_WIDTH-1:0] a
  );
    return (a >> 2) < DEPTH;
  endfunction

  function automatic logic [IDX_W-1:0] widx(
    input logic [IMEM_ADDR_WIDTH-1:0] a
  );
    return a[IDX_W+1:2];
  endfunction

  logic [REG_DATA_WIDTH-1:0] mem [IMEM_DATA_DEPTH];

  state_t                     state;
  state_t                     state_n;
  logic [2:0]                 cnt;
  logic [2:0]                 cnt_n;
  logic [IMEM_ADDR_WIDTH-1:0] pend_addr;
  logic                       accept;
  logic                       sample;
  logic                       from_req;
  logic [IMEM_ADDR_WIDTH-1:0] sel_addr;
  logic                       sel_err;

  // Loader writes land regardless of FSM state; array survives reset.
  always_ff @(posedge Clk_100MHz) begin
    if (Prog_we && in_range(Prog_addr)) begin
      mem[widx(Prog_addr)] <= Prog_wdata;
    end
  end

  always_comb begin
    IF_req_ready = 1'b0;
    unique case (state)
      S_IDLE: IF_req_ready = !Prog_we && !IF_flush && !Reset;
      S_RESP: IF_req_ready = IF_rsp_ready && !Prog_we &&
                             !IF_flush && !Reset;
      default: IF_req_ready = 1'b0;
    endcase
  end

  assign accept = IF_req_valid && IF_req_ready;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sample   = 1'b0;
    from_req = 1'b0;
    unique case (state)
      S_IDLE: state_n = S_IDLE;
      S_WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_n = S_RESP;
          sample  = 1'b1;
        end
      end
      S_RESP: begin
        if (IF_rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Accept only happens in IDLE or on a consuming RESP edge.
    if (accept) begin
      if (WS == 3'd0) begin
        state_n  = S_RESP;
        sample   = 1'b1;
        from_req = 1'b1;
      end else begin
        state_n = S_WAIT;
        cnt_n   = WS;
      end
    end
    if (IF_flush) begin
      state_n  = S_IDLE;
      cnt_n    = 3'd0;
      sample   = 1'b0;
      from_req = 1'b0;
    end
  end

  assign sel_addr = from_req ? IF_req_addr : pend_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || !in_range(sel_addr);

  always_ff @(posedge Clk_100MHz) begin
    if (Reset) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      pend_addr    <= '0;
      IF_rsp_valid <= 1'b0;
      IF_rsp_instr <= NOP;
      IF_rsp_addr  <= '0;
      IF_rsp_error <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      IF_rsp_valid <= (state_n == S_RESP);
      if (accept) pend_addr <= IF_req_addr;
      if (sample) begin
        IF_rsp_addr  <= sel_addr;
        IF_rsp_error <= sel_err;
        if (sel_err) IF_rsp_instr <= NOP;
        else         IF_rsp_instr <= mem[widx(sel_addr)];
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: W=1 vector table plus W=0 and W=3
// instances for streaming and flush sequences.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        flush;
  logic        we;
  logic [31:0] paddr;
  logic [31:0] pwdata;

  logic        rdy1, v1, e1;
  logic [31:0] i1, a1;
  logic        rdy0, v0, e0;
  logic [31:0] i0, a0;
  logic        rdy3, v3, e3;
  logic [31:0] i3, a3;

  imem_fetch_responder #(.WAIT_STATES(1)) u1 (
    .Clk_100MHz(clk), .Reset(rst),
    .IF_req_valid(req_valid), .IF_req_addr(req_addr),
    .IF_req_ready(rdy1), .IF_rsp_valid(v1),
    .IF_rsp_instr(i1), .IF_rsp_addr(a1),
    .IF_rsp_error(e1), .IF_rsp_ready(rsp_ready),
    .IF_flush(flush), .Prog_we(we),
    .Prog_addr(paddr), .Prog_wdata(pwdata)
  );

  imem_fetch_responder #(.WAIT_STATES(0)) u0 (
    .Clk_100MHz(clk), .Reset(rst),
    .IF_req_valid(req_valid), .IF_req_addr(req_addr),
    .IF_req_ready(rdy0), .IF_rsp_valid(v0),
    .IF_rsp_instr(i0), .IF_rsp_addr(a0),
    .IF_rsp_error(e0), .IF_rsp_ready(rsp_ready),
    .IF_flush(flush), .Prog_we(we),
    .Prog_addr(paddr), .Prog_wdata(pwdata)
  );

  imem_fetch_responder #(.WAIT_STATES(3)) u3 (
    .Clk_100MHz(clk), .Reset(rst),
    .IF_req_valid(req_valid), .IF_req_addr(req_addr),
    .IF_req_ready(rdy3), .IF_rsp_valid(v3),
    .IF_rsp_instr(i3), .IF_rsp_addr(a3),
    .IF_rsp_error(e3), .IF_rsp_ready(rsp_ready),
    .IF_flush(flush), .Prog_we(we),
    .Prog_addr(paddr), .Prog_wdata(pwdata)
  );

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        rr;
    logic        we;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_i;
    logic [31:0] e_a;
    logic        e_e;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog [4];

  task automatic chk1(input string name, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    we        = 1'b0;
    paddr     = 32'h0;
    pwdata    = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    we     = 1'b1;
    paddr  = a;
    pwdata = d;
    tick();
    we     = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic v, input logic [31:0] a, input logic rr,
    input logic w, input logic e_rdy, input logic e_v,
    input logic [31:0] e_i, input logic [31:0] e_a, input logic e_e
  );
    vec_t r;
    r.v = v; r.a = a; r.rr = rr; r.we = w;
    r.e_rdy = e_rdy; r.e_v = e_v;
    r.e_i = e_i; r.e_a = e_a; r.e_e = e_e;
    return r;
  endfunction

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;

    tbl[0]  = mk(1, 32'h0,    1, 0, 1, 0, 32'h13,     32'h0,    0);
    tbl[1]  = mk(1, 32'h4,    1, 0, 0, 1, prog[0],    32'h0,    0);
    tbl[2]  = mk(1, 32'h4,    1, 0, 1, 0, prog[0],    32'h0,    0);
    tbl[3]  = mk(1, 32'h8,    1, 0, 0, 1, prog[1],    32'h4,    0);
    tbl[4]  = mk(1, 32'h8,    1, 0, 1, 0, prog[1],    32'h4,    0);
    tbl[5]  = mk(1, 32'hC,    1, 0, 0, 1, prog[2],    32'h8,    0);
    tbl[6]  = mk(1, 32'hC,    1, 0, 1, 0, prog[2],    32'h8,    0);
    tbl[7]  = mk(0, 32'h0,    1, 0, 0, 1, prog[3],    32'hC,    0);
    tbl[8]  = mk(1, 32'h4,    1, 0, 1, 0, prog[3],    32'hC,    0);
    tbl[9]  = mk(1, 32'h8,    0, 0, 0, 1, prog[1],    32'h4,    0);
    tbl[10] = mk(1, 32'h8,    0, 0, 0, 1, prog[1],    32'h4,    0);
    tbl[11] = mk(1, 32'h8,    0, 0, 0, 1, prog[1],    32'h4,    0);
    tbl[12] = mk(1, 32'h8,    0, 0, 0, 1, prog[1],    32'h4,    0);
    tbl[13] = mk(1, 32'h8,    1, 0, 1, 0, prog[1],    32'h4,    0);
    tbl[14] = mk(0, 32'h0,    1, 0, 0, 1, prog[2],    32'h8,    0);
    tbl[15] = mk(0, 32'h0,    1, 0, 1, 0, prog[2],    32'h8,    0);
    tbl[16] = mk(1, 32'h6,    1, 0, 1, 0, prog[2],    32'h8,    0);
    tbl[17] = mk(0, 32'h0,    1, 0, 0, 1, 32'h13,     32'h6,    1);
    tbl[18] = mk(1, 32'h1000, 1, 0, 1, 0, 32'h13,     32'h6,    1);
    tbl[19] = mk(0, 32'h0,    1, 0, 0, 1, 32'h13,     32'h1000, 1);
    tbl[20] = mk(1, 32'h0,    1, 0, 1, 0, 32'h13,     32'h1000, 1);
    tbl[21] = mk(0, 32'h0,    1, 0, 0, 1, prog[0],    32'h0,    0);
    tbl[22] = mk(0, 32'h0,    1, 0, 1, 0, prog[0],    32'h0,    0);
    tbl[23] = mk(1, 32'h4,    1, 1, 0, 0, prog[0],    32'h0,    0);
    tbl[24] = mk(0, 32'h0,    1, 0, 1, 0, prog[0],    32'h0,    0);

    idle_inputs();
    rst = 1'b1;
    tick();
    #1;
    chk1("rst_rdy1", rdy1, 1'b0);
    tick();
    chk1("rst_v1", v1, 1'b0);
    chk32("rst_i1", i1, 32'h13);
    chk32("rst_a1", a1, 32'h0);
    chk1("rst_e1", e1, 1'b0);
    chk1("rst_v0", v0, 1'b0);
    chk32("rst_i3", i3, 32'h13);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) load(32'(k * 4), prog[k]);
    load(32'h40, 32'h0100_0213);

    // W=1 main table
    for (int n = 0; n < NV; n++) begin
      req_valid = tbl[n].v;
      req_addr  = tbl[n].a;
      rsp_ready = tbl[n].rr;
      we        = tbl[n].we;
      paddr     = 32'h100;
      pwdata    = 32'h1111_1111;
      #1;
      chk1($sformatf("vec%0d_rdy", n), rdy1, tbl[n].e_rdy);
      tick();
      chk1($sformatf("vec%0d_valid", n), v1, tbl[n].e_v);
      chk32($sformatf("vec%0d_instr", n), i1, tbl[n].e_i);
      chk32($sformatf("vec%0d_addr", n), a1, tbl[n].e_a);
      chk1($sformatf("vec%0d_err", n), e1, tbl[n].e_e);
    end

    // W=0 streaming
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'(k * 4);
      #1;
      chk1($sformatf("s0_rdy%0d", k), rdy0, 1'b1);
      tick();
      chk1($sformatf("s0_valid%0d", k), v0, 1'b1);
      chk32($sformatf("s0_instr%0d", k), i0, prog[k]);
      chk32($sformatf("s0_addr%0d", k), a0, 32'(k * 4));
    end
    req_valid = 1'b0;
    tick();
    chk1("s0_drain", v0, 1'b0);

    // W=3 flush during WAIT
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h8;
    #1;
    chk1("fl_rdy_acc", rdy3, 1'b1);
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    #1;
    chk1("fl_rdy_flush", rdy3, 1'b0);
    tick();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1($sformatf("fl_none%0d", k), v3, 1'b0);
    end
    req_valid = 1'b1;
    req_addr  = 32'h40;
    #1;
    chk1("fl_rdy_new", rdy3, 1'b1);
    tick();
    req_valid = 1'b0;
    chk1("fl_lat0", v3, 1'b0);
    tick();
    chk1("fl_lat1", v3, 1'b0);
    tick();
    chk1("fl_lat2", v3, 1'b0);
    tick();
    chk1("fl_valid", v3, 1'b1);
    chk32("fl_instr", i3, 32'h0100_0213);
    chk32("fl_addr", a3, 32'h40);
    chk1("fl_err", e3, 1'b0);
    tick();
    chk1("fl_done", v3, 1'b0);

    // Reset while in RESP, array persists
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk1("rr_valid", v1, 1'b1);
    chk32("rr_instr", i1, prog[0]);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk1("rr_rdy_in_rst", rdy1, 1'b0);
    tick();
    chk1("rr_valid_clr", v1, 1'b0);
    chk32("rr_instr_nop", i1, 32'h13);
    chk32("rr_addr_clr", a1, 32'h0);
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    #1;
    chk1("rr_first_acc", rdy1, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    chk1("rr_persist_v", v1, 1'b1);
    chk32("rr_persist_i", i1, prog[1]);
    chk32("rr_persist_a", a1, 32'h4);
    tick();

    // Write collides with sample edge: old data, then new on refetch
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    we        = 1'b1;
    paddr     = 32'h0;
    pwdata    = 32'hABCD_0037;
    tick();
    we = 1'b0;
    chk1("wc_valid", v1, 1'b1);
    chk32("wc_old", i1, prog[0]);
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    chk1("wc_re_valid", v1, 1'b1);
    chk32("wc_new", i1, 32'hABCD_0037);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
